// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 8-bit ALU: captures A, B and the select from one shared
// bus in three strobed transfers, holds them toward the ALU and latches the result.
module alu_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 2,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [SEL_W-1:0] sel,
    output logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             overrun,
    output logic [2:0]       phase
);

    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(ALU_LAT);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    logic             load_q;
    logic             ld_edge;
    logic [CNT_W-1:0] lat_cnt;

    // load_q clears in reset, so a load already high at release counts as an edge.
    assign ld_edge   = load & ~load_q;
    assign alu_valid = (state == S_EXEC);
    assign busy      = (state == S_EXEC);
    assign phase     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_A;
            load_q       <= 1'b0;
            lat_cnt      <= '0;
            a            <= '0;
            b            <= '0;
            sel          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            load_q <= load;
            // clr swallows any coincident edge: no capture, no overrun.
            if (clr) begin
                state        <= S_A;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    S_A: begin
                        if (ld_edge) begin
                            a     <= data_in;
                            state <= S_B;
                        end
                    end
                    S_B: begin
                        if (ld_edge) begin
                            b     <= data_in;
                            state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (ld_edge) begin
                            sel     <= data_in[SEL_W-1:0];
                            lat_cnt <= '0;
                            state   <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (ld_edge) begin
                            overrun <= 1'b1;
                        end
                        if (lat_cnt == LAT_MAX) begin
                            result       <= alu_result;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        // This edge is already operand A of the next operation.
                        if (ld_edge) begin
                            a            <= data_in;
                            result_valid <= 1'b0;
                            state        <= S_B;
                        end
                    end
                    default: begin
                        state <= S_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a combinational-ALU instance driven from a vector
// table, plus a two-cycle registered-ALU instance for the latency and overrun cases.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load;
    logic       clr;
    logic [7:0] a0, b0, result0, alu_res0;
    logic [1:0] sel0;
    logic       alu_valid0, result_valid0, busy0, overrun0;
    logic [2:0] phase0;

    logic [7:0] data2;
    logic       load2;
    logic [7:0] a2, b2, result2, alu_res2;
    logic [1:0] sel2;
    logic       alu_valid2, result_valid2, busy2, overrun2;
    logic [2:0] phase2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] s);
        case (s)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    assign alu_res0 = alu_f(a0, b0, sel0);
    always_ff @(posedge clk) alu_res2 <= alu_f(a2, b2, sel2);

    alu_operand_sequencer #(.WIDTH(8), .SEL_W(2), .ALU_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clr(clr),
        .a(a0), .b(b0), .sel(sel0), .alu_valid(alu_valid0), .alu_result(alu_res0),
        .result(result0), .result_valid(result_valid0), .busy(busy0),
        .overrun(overrun0), .phase(phase0)
    );

    alu_operand_sequencer #(.WIDTH(8), .SEL_W(2), .ALU_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data2), .load(load2), .clr(1'b0),
        .a(a2), .b(b2), .sel(sel2), .alu_valid(alu_valid2), .alu_result(alu_res2),
        .result(result2), .result_valid(result_valid2), .busy(busy2),
        .overrun(overrun2), .phase(phase2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] d, input logic l, input logic c);
        data_in = d;
        load    = l;
        clr     = c;
        tick();
    endtask

    task automatic step2(input logic [7:0] d, input logic l);
        data2 = d;
        load2 = l;
        tick();
    endtask

    typedef struct {
        logic [7:0] d;
        logic       ld;
        logic       cl;
        logic [2:0] ph;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] es;
        logic [7:0] er;
        logic       rv;
    } vec_t;

    vec_t vt[30];

    initial begin
        int   busy_cnt;
        logic prev_rv;

        // d, ld, clr | phase, a, b, sel, result, result_valid
        vt[0]  = '{8'h12, 1'b1, 1'b0, 3'd1, 8'h12, 8'h00, 2'd0, 8'h00, 1'b0};
        vt[1]  = '{8'h12, 1'b0, 1'b0, 3'd1, 8'h12, 8'h00, 2'd0, 8'h00, 1'b0};
        vt[2]  = '{8'h34, 1'b1, 1'b0, 3'd2, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0};
        vt[3]  = '{8'h34, 1'b0, 1'b0, 3'd2, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0};
        vt[4]  = '{8'h00, 1'b1, 1'b0, 3'd3, 8'h12, 8'h34, 2'd0, 8'h00, 1'b0};
        vt[5]  = '{8'h00, 1'b0, 1'b0, 3'd4, 8'h12, 8'h34, 2'd0, 8'h46, 1'b1};
        vt[6]  = '{8'h00, 1'b0, 1'b0, 3'd4, 8'h12, 8'h34, 2'd0, 8'h46, 1'b1};
        vt[7]  = '{8'hAA, 1'b1, 1'b0, 3'd1, 8'hAA, 8'h34, 2'd0, 8'h46, 1'b0};
        vt[8]  = '{8'hAA, 1'b0, 1'b0, 3'd1, 8'hAA, 8'h34, 2'd0, 8'h46, 1'b0};
        vt[9]  = '{8'h01, 1'b1, 1'b0, 3'd2, 8'hAA, 8'h01, 2'd0, 8'h46, 1'b0};
        vt[10] = '{8'h01, 1'b0, 1'b0, 3'd2, 8'hAA, 8'h01, 2'd0, 8'h46, 1'b0};
        vt[11] = '{8'hFC, 1'b1, 1'b0, 3'd3, 8'hAA, 8'h01, 2'd0, 8'h46, 1'b0};
        vt[12] = '{8'hFC, 1'b0, 1'b0, 3'd4, 8'hAA, 8'h01, 2'd0, 8'hAB, 1'b1};
        vt[13] = '{8'h00, 1'b0, 1'b0, 3'd4, 8'hAA, 8'h01, 2'd0, 8'hAB, 1'b1};
        vt[14] = '{8'h55, 1'b1, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[15] = '{8'h55, 1'b1, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[16] = '{8'h55, 1'b1, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[17] = '{8'h55, 1'b1, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[18] = '{8'h55, 1'b1, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[19] = '{8'h55, 1'b0, 1'b0, 3'd1, 8'h55, 8'h01, 2'd0, 8'hAB, 1'b0};
        vt[20] = '{8'h66, 1'b1, 1'b0, 3'd2, 8'h55, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[21] = '{8'h66, 1'b0, 1'b0, 3'd2, 8'h55, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[22] = '{8'h03, 1'b1, 1'b1, 3'd0, 8'h55, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[23] = '{8'h03, 1'b0, 1'b0, 3'd0, 8'h55, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[24] = '{8'h07, 1'b1, 1'b0, 3'd1, 8'h07, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[25] = '{8'h07, 1'b0, 1'b0, 3'd1, 8'h07, 8'h66, 2'd0, 8'hAB, 1'b0};
        vt[26] = '{8'h05, 1'b1, 1'b0, 3'd2, 8'h07, 8'h05, 2'd0, 8'hAB, 1'b0};
        vt[27] = '{8'h05, 1'b0, 1'b0, 3'd2, 8'h07, 8'h05, 2'd0, 8'hAB, 1'b0};
        vt[28] = '{8'h02, 1'b1, 1'b0, 3'd3, 8'h07, 8'h05, 2'd2, 8'hAB, 1'b0};
        vt[29] = '{8'h00, 1'b0, 1'b0, 3'd4, 8'h07, 8'h05, 2'd2, 8'h05, 1'b1};
        exp_q.push_back(8'h46);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h05);

        // Clock/reset
        rst = 1'b1; data_in = 8'h00; load = 1'b0; clr = 1'b0;
        data2 = 8'h00; load2 = 1'b0;
        repeat (2) tick();
        check("rst_a", a0, 8'h00);
        check("rst_b", b0, 8'h00);
        check("rst_sel", sel0, 2'd0);
        check("rst_result", result0, 8'h00);
        check("rst_rv", result_valid0, 1'b0);
        check("rst_alu_valid", alu_valid0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_overrun", overrun0, 1'b0);
        check("rst_phase", phase0, 3'd0);
        check("rst_phase2", phase2, 3'd0);
        rst = 1'b0;

        // Table-driven vectors on the combinational-ALU instance
        prev_rv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(vt[i].d, vt[i].ld, vt[i].cl);
            check($sformatf("v%0d_phase", i), phase0, vt[i].ph);
            check($sformatf("v%0d_a", i), a0, vt[i].ea);
            check($sformatf("v%0d_b", i), b0, vt[i].eb);
            check($sformatf("v%0d_sel", i), sel0, vt[i].es);
            check($sformatf("v%0d_result", i), result0, vt[i].er);
            check($sformatf("v%0d_rv", i), result_valid0, vt[i].rv);
            check($sformatf("v%0d_busy", i), busy0, vt[i].ph == 3'd3);
            check($sformatf("v%0d_alu_valid", i), alu_valid0, vt[i].ph == 3'd3);
            check($sformatf("v%0d_overrun", i), overrun0, 1'b0);
            if (result_valid0 && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1'b1, 1'b0);
                end else begin
                    check("sb_result", result0, exp_q.pop_front());
                end
            end
            prev_rv = result_valid0;
        end
        check("sb_queue_empty", exp_q.size(), 0);

        // ALU_LAT=2: three busy cycles, overrun on an edge while busy
        step2(8'h10, 1'b1);
        step2(8'h10, 1'b0);
        step2(8'h20, 1'b1);
        step2(8'h20, 1'b0);
        step2(8'h05, 1'b1);
        busy_cnt = 0;
        if (busy2) busy_cnt++;
        check("lat2_sel", sel2, 2'd1);
        step2(8'h00, 1'b0);
        if (busy2) busy_cnt++;
        check("lat2_rv_early", result_valid2, 1'b0);
        step2(8'h99, 1'b1);
        if (busy2) busy_cnt++;
        check("lat2_overrun", overrun2, 1'b1);
        check("lat2_phase_hold", phase2, 3'd3);
        check("lat2_a_frozen", a2, 8'h10);
        check("lat2_rv_mid", result_valid2, 1'b0);
        step2(8'h00, 1'b0);
        if (busy2) busy_cnt++;
        step2(8'h00, 1'b0);
        if (busy2) busy_cnt++;
        check("lat2_busy_cycles", busy_cnt, 3);
        check("lat2_phase_done", phase2, 3'd4);
        check("lat2_result", result2, 8'hF0);
        check("lat2_rv", result_valid2, 1'b1);
        check("lat2_overrun_sticky", overrun2, 1'b1);

        // Reset in S_EXEC with load held high across release
        step(8'h03, 1'b1, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        check("pre_rst_phase", phase0, 3'd3);
        rst = 1'b1;
        step(8'h5A, 1'b1, 1'b0);
        check("mid_rst_phase", phase0, 3'd0);
        check("mid_rst_a", a0, 8'h00);
        check("mid_rst_b", b0, 8'h00);
        check("mid_rst_sel", sel0, 2'd0);
        check("mid_rst_result", result0, 8'h00);
        check("mid_rst_rv", result_valid0, 1'b0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_overrun2", overrun2, 1'b0);
        rst = 1'b0;
        step(8'h5A, 1'b1, 1'b0);
        check("post_rst_a", a0, 8'h5A);
        check("post_rst_phase", phase0, 3'd1);
        step(8'h5A, 1'b0, 1'b0);
        check("post_rst_hold", phase0, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream stage that feeds the 8-bit ALU through the shared 8-bit input bus of the top-level wrapper. Input pins are too few to present A, B and the operation select at once, so this block captures them in three strobed bus transfers. It holds the operands and select steady toward the ALU and samples the ALU result into a hold register. It raises a result-valid flag for the output stage.

Parameters:
WIDTH, 8, operand and result width
SEL_W, 2, operation-select width, taken from data_in[SEL_W-1:0]
ALU_LAT, 0, ALU latency in clocks; 0 = combinational ALU

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
data_in  input  WIDTH  shared bus: A, then B, then select
load  input  1  level strobe from pin; one transfer per rising edge
clr  input  1  synchronous abort back to operand-A phase
a  output  WIDTH  registered operand A to ALU
b  output  WIDTH  registered operand B to ALU
sel  output  SEL_W  registered operation select to ALU
alu_valid  output  1  high while the ALU inputs are being evaluated
alu_result  input  WIDTH  ALU result
result  output  WIDTH  held result
result_valid  output  1  result holds a completed operation
busy  output  1  high in S_EXEC
overrun  output  1  sticky: load edge arrived while busy
phase  output  3  state code for debug pins

Behaviour:
- Reset values when rst=1 at a clock edge: a=0, b=0, sel=0, result=0, result_valid=0, alu_valid=0, busy=0, overrun=0, load_q=0, lat_cnt=0, state=S_A.
- Edge detect:
  - load_q is the registered copy of load.
  - ld_edge = load & ~load_q.
  - If load is already high when rst drops, that counts as an edge in the first post-reset cycle.
- States and phase codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4. Codes 5–7 are illegal and recover to S_A on the next edge.
- S_A: on ld_edge, a<=data_in and go to S_B.
- S_B: on ld_edge, b<=data_in and go to S_OP.
- S_OP: on ld_edge, sel<=data_in[SEL_W-1:0] (upper bits ignored), lat_cnt<=0, and go to S_EXEC.
- S_EXEC:
  - alu_valid=1 and busy=1.
  - a, b and sel are frozen.
  - When lat_cnt==ALU_LAT: result<=alu_result, result_valid<=1, and go to S_DONE. Otherwise lat_cnt increments.
  - Dwell in S_EXEC is exactly ALU_LAT+1 cycles.
- S_DONE:
  - result and result_valid are held.
  - On ld_edge: a<=data_in, result_valid<=0, and go to S_B. That edge is the first transfer of the next operation.
  - result keeps its old value until overwritten.
- Latency with ALU_LAT=0: the select edge is captured at edge k, alu_valid is high in cycle k+1, and result_valid is first high in cycle k+2.
- alu_valid, busy and phase are decoded from state (combinational). result_valid and overrun are registers.
- Overrun: a ld_edge in S_EXEC is ignored (no capture, no transition) and sets overrun. overrun is cleared only by rst.
- clr (any state, synchronous):
  - state<=S_A and result_valid<=0.
  - a, b, sel, result and overrun are held.
  - clr has priority over ld_edge in the same cycle; that edge is consumed and nothing is captured.
- rst has priority over clr and load. Reset mid-operation discards partial operands.
- A load held high yields exactly one transfer. A new transfer needs load to go low for at least one cycle first.

Test Plan:
- Normal op, ALU stub sel=0 → a+b: load edges with data 0x12, 0x34, 0x00. The ALU sees a=0x12, b=0x34, sel=0. result=0x46 with result_valid high 2 cycles after the third edge.
- Held strobe: load high for 5 cycles with data 0x55. Only a=0x55 is captured, phase=1 and b is unchanged. Drop and reassert load to capture b.
- ALU_LAT=2 with a registered ALU stub: busy is high exactly 3 cycles and result samples the stub output. A load edge during busy sets overrun=1, and phase stays 3.
- Back-to-back: in S_DONE with result=0x46, an edge with 0xAA clears result_valid and sets a=0xAA, while result stays 0x46. Complete B=0x01, sel=0 → result=0xAB.
- clr coincident with load edge in S_OP: the state goes to S_A, sel is unchanged and result_valid=0. The next edge captures A.
- rst asserted in S_EXEC: all outputs are 0 on the next cycle and phase=0. With load high at reset release, the first post-reset cycle captures A.
